snail_pattern_fsm: RTL and testbench
====================================

Name: snail_pattern_fsm

Overview:
Programmable Mealy sequence detector. Generalises the fixed five-bit serial-pattern detector to a run-time loadable pattern of 1..MAX_W bits.
- Selectable overlapping or non-overlapping detection.
- Saturating match counter.
- Sits on a serial bit stream gated by a clock-enable, as used in the lab FSM exercises.

Parameters:
MAX_W, 8, maximum pattern length in bits (>= 2)
LEN_W, $clog2(MAX_W+1), width of the pattern-length field
CNT_W, 8, width of the saturating match counter

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
en  in  1  stream enable; input bit a is consumed only when en=1
a  in  1  serial input bit
cfg_load  in  1  one-cycle pulse; captures cfg_pattern, cfg_len, cfg_overlap
cfg_pattern  in  MAX_W  pattern; bit cfg_len-1 arrives first, bit 0 arrives last
cfg_len  in  LEN_W  pattern length, valid range 1..MAX_W
cfg_overlap  in  1  1 = overlapping detection, 0 = window restarts after a match
y  out  1  Mealy match flag, combinational from current state and a
match_cnt  out  CNT_W  number of matches since reset/cfg_load, saturating
armed  out  1  registered; 1 when a valid configuration is loaded

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). No asynchronous reset.
- Reset values: state=IDLE, armed=0, match_cnt=0, history=0, fill=0, stored pattern/len/overlap=0. y=0 in IDLE regardless of a.
- States (enum): IDLE (no valid config) and RUN.
- IDLE -> RUN on cfg_load with 1 <= cfg_len <= MAX_W.
- RUN -> IDLE on cfg_load with cfg_len = 0 or cfg_len > MAX_W.
- RUN -> RUN on a valid cfg_load: reloads config and restarts the window.
- Every cfg_load, valid or not, clears history, fill and match_cnt.
- armed = (state == RUN), registered.
- Datapath in RUN:
  - hist is a MAX_W-1 bit shift register.
  - fill is a saturating count of valid history bits, 0..MAX_W-1.
  - window = {hist, a}.
- Mealy output: y = (state==RUN) & en & ~cfg_load & (fill >= len-1) & (window[len-1:0] == pattern[len-1:0]). len=1 matches on the current bit alone.
- Update when en=1 and no cfg_load:
  - hist <= {hist[MAX_W-3:0], a}; fill <= min(fill+1, MAX_W-1).
  - If y=1 and overlap=0: fill <= 0, so the next match needs len fresh bits. hist content is don't-care after this.
  - If y=1 and overlap=1: no special action; shifting continues.
- en=0: all state holds, y=0, a ignored.
- Counter: match_cnt increments on each cycle with y=1. It sticks at 2^CNT_W-1 and never wraps.
- Priority per cycle: rst > cfg_load > en. cfg_load with en=1 drops that a bit and forces y=0.
- Latency: y is valid in the same cycle as the last pattern bit. match_cnt reflects a match one cycle later.
- Reset mid-stream discards partial matches and configuration; a cfg_load is needed to re-arm.

Decomposition:
- Package snail_pattern_pkg holds:
  - state_e enum (IDLE, RUN) as 1-bit enum;
  - localparam for default pattern 5'b10110, length 5, non-overlap (the lab's classic pattern).
- Sub-module sat_counter #(W) (clk, rst, clr, inc, cnt) implements the match counter.
- History, fill and the FSM stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with a toggling -> y=0, armed=0, match_cnt=0. Stream bits while unconfigured -> y stays 0.
- Non-overlap, pattern=10110, len=5: stream 1,0,1,1,0,1,1,0 -> y=1 on bit 5 only, match_cnt=1. With overlap=1 the same stream gives y=1 on bits 5 and 8, match_cnt=2.
- Pattern=101, len=3: stream 1,0,1,0,1 with overlap=1 -> y=1 on bits 3 and 5. With overlap=0 -> y=1 on bit 3 only.
- en gaps: pattern 10110, insert en=0 cycles (a random) between every bit -> same match cycles as the gap-free stream, y=0 whenever en=0.
- Saturation, CNT_W=2: pattern=1, len=1, stream six 1s -> match_cnt sequence 1, 2, 3, 3, 3, 3.
- Config edges:
  - cfg_len=0 -> armed=0 next cycle and y=0 thereafter.
  - cfg_load coinciding with en=1 and the final pattern bit -> y=0 and match_cnt=0.
  - rst mid-pattern (after 1,0,1) followed by cfg_load and 1,0 -> no match.

Source files
------------

// File: rtl/snail_pattern_pkg.sv
// Shared types and defaults for the programmable serial-pattern detector.
// The defaults describe the lab's classic 5-bit pattern.
package snail_pattern_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [4:0] DEF_PATTERN = 5'b10110;
  localparam int         DEF_LEN     = 5;
  localparam logic       DEF_OVERLAP = 1'b0;

  function automatic logic len_ok(input int len, input int max_w);
    return (len >= 1) && (len <= max_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; clr has priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snail_pattern_fsm.sv
// Run-time programmable Mealy sequence detector on an enable-gated bit stream,
// with overlapping / non-overlapping detection and a saturating match count.
//
// state | meaning
// IDLE  | no valid pattern loaded, y held low
// RUN   | pattern loaded, window compared against every enabled bit
module snail_pattern_fsm
  import snail_pattern_pkg::*;
#(
  parameter int MAX_W = 8,
  parameter int LEN_W = $clog2(MAX_W + 1),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             cfg_load,
  input  logic [MAX_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_W - 1);

  state_e state, state_next;

  logic [MAX_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [MAX_W-2:0] hist;
  logic [LEN_W-1:0] fill;

  logic [MAX_W-1:0] window;
  logic [MAX_W-1:0] mask;
  logic             cfg_valid;
  logic             full_enough;
  logic             hit;

  assign cfg_valid   = len_ok(int'(cfg_len), MAX_W);
  assign window      = {hist, a};
  // fill >= len-1, rearranged so len=0 cannot underflow
  assign full_enough = ({1'b0, fill} + 1'b1) >= {1'b0, len_q};
  assign hit         = ((window ^ pat_q) & mask) == '0;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state;
    if (cfg_load) begin
      state_next = cfg_valid ? RUN : IDLE;
    end
  end

  always_comb begin
    y = (state == RUN) && en && !cfg_load && full_enough && hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      hist  <= '0;
      fill  <= '0;
    end else if (cfg_load) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
      hist  <= '0;
      fill  <= '0;
    end else if (en && (state == RUN)) begin
      hist <= window[MAX_W-2:0];
      // non-overlap: the next match must be built from fresh bits only
      if (y && !ovl_q) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cfg_load),
    .inc(y),
    .cnt(match_cnt)
  );

endmodule

// File: tb/tb_snail_pattern_fsm.sv
// Directed bench for snail_pattern_fsm: the driver queues expected y/count/armed
// per cycle, a negedge monitor pops and compares.
module tb_snail_pattern_fsm;

  localparam int MAX_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             a;
  logic             cfg_load;
  logic [MAX_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  typedef struct {
    string            name;
    logic             y;
    logic [CNT_W-1:0] cnt;
    logic             armed;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;
  bit   m_armed = 1'b0;

  always #5 clk = ~clk;

  snail_pattern_fsm #(
    .MAX_W(MAX_W),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .a(a),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .y(y),
    .match_cnt(match_cnt),
    .armed(armed)
  );

  task automatic chk(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "y", 8'(y), 8'(e.y));
        chk(e.name, "match_cnt", 8'(match_cnt), 8'(e.cnt));
        chk(e.name, "armed", 8'(armed), 8'(e.armed));
      end
    end
  end

  task automatic push(input string name, input logic ey);
    exp_t e;
    e.name  = name;
    e.y     = ey;
    e.cnt   = CNT_W'(m_cnt);
    e.armed = m_armed;
    sb.push_back(e);
  endtask

  task automatic step(input logic e_en, input logic e_a, input logic ey, input string name);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cfg_load = 1'b0;
    en       = e_en;
    a        = e_a;
    push(name, ey);
    if (ey && (m_cnt < CNT_MAX)) m_cnt++;
  endtask

  task automatic cfg(input logic [MAX_W-1:0] pat, input int len, input logic ov,
                     input logic e_en, input logic e_a, input string name);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ov;
    en          = e_en;
    a           = e_a;
    push(name, 1'b0);
    m_cnt   = 0;
    m_armed = (len >= 1) && (len <= MAX_W);
  endtask

  // only the cycles after the first reset edge are checked
  task automatic do_reset(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      rst      = 1'b1;
      cfg_load = 1'b0;
      en       = 1'b1;
      a        = i[0];
      if (i > 0) push(name, 1'b0);
      m_cnt   = 0;
      m_armed = 1'b0;
    end
  endtask

  // bits and expected y listed first-arriving bit in the MSB of the n-bit field
  task automatic stream(input logic [15:0] bits, input logic [15:0] ys, input int n, input string name);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], ys[i], $sformatf("%s[%0d]", name, n - 1 - i));
    end
  endtask

  initial begin : driver
    logic [4:0] gap_bits;
    logic [4:0] gap_ys;
    rst = 1'b1; en = 1'b0; a = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

    do_reset(2, "reset");
    stream(16'b101, 16'b000, 3, "unconfigured");

    cfg(8'b10110, 5, 1'b0, 1'b0, 1'b0, "cfg_nov");
    stream(16'b10110110, 16'b00001000, 8, "nov5");
    cfg(8'b10110, 5, 1'b1, 1'b0, 1'b0, "cfg_ov");
    stream(16'b10110110, 16'b00001001, 8, "ov5");

    cfg(8'b101, 3, 1'b1, 1'b0, 1'b0, "cfg_101_ov");
    stream(16'b10101, 16'b00101, 5, "ov3");
    cfg(8'b101, 3, 1'b0, 1'b0, 1'b0, "cfg_101_nov");
    stream(16'b10101, 16'b00100, 5, "nov3");

    cfg(8'b10110, 5, 1'b0, 1'b0, 1'b0, "cfg_gap");
    gap_bits = 5'b10110;
    gap_ys   = 5'b00001;
    for (int i = 4; i >= 0; i--) begin
      step(1'b0, 1'($urandom_range(1, 0)), 1'b0, $sformatf("gap_off[%0d]", 4 - i));
      step(1'b1, gap_bits[i], gap_ys[i], $sformatf("gap_on[%0d]", 4 - i));
    end
    step(1'b0, 1'b1, 1'b0, "gap_tail");

    cfg(8'b1, 1, 1'b0, 1'b0, 1'b0, "cfg_len1");
    stream(16'b111111, 16'b111111, 6, "sat");
    step(1'b0, 1'b1, 1'b0, "sat_hold");

    cfg(8'b1, 0, 1'b0, 1'b0, 1'b0, "cfg_len0");
    stream(16'b1111, 16'b0000, 4, "len0");

    cfg(8'b11001010, 8, 1'b1, 1'b0, 1'b0, "cfg_full");
    stream(16'b11001010, 16'b00000001, 8, "full8");
    cfg(8'b11001010, 9, 1'b1, 1'b0, 1'b0, "cfg_len9");
    stream(16'b11001010, 16'b00000000, 8, "len9");

    cfg(8'b10110, 5, 1'b0, 1'b0, 1'b0, "cfg_clash");
    stream(16'b1011, 16'b0000, 4, "clash_pre");
    cfg(8'b10110, 5, 1'b0, 1'b1, 1'b0, "clash_load");
    stream(16'b10110, 16'b00001, 5, "clash_post");

    cfg(8'b10110, 5, 1'b0, 1'b0, 1'b0, "cfg_midrst");
    stream(16'b101, 16'b000, 3, "midrst_pre");
    do_reset(1, "midrst");
    cfg(8'b10110, 5, 1'b0, 1'b0, 1'b0, "cfg_after_rst");
    stream(16'b10, 16'b00, 2, "midrst_post");
    step(1'b0, 1'b0, 1'b0, "midrst_idle");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
